// File: rtl/lowpass_pkg.sv
// rtl/lowpass_pkg.sv - shared state encoding and border bit positions for the low-pass frame sequencer
package lowpass_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PROC,
    DRAIN,
    DONE
  } state_e;

  localparam int BRD_TOP    = 3;
  localparam int BRD_BOTTOM = 2;
  localparam int BRD_LEFT   = 1;
  localparam int BRD_RIGHT  = 0;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column-major (row inner) raster position counter that parks on the last pixel
module raster_counter #(
  parameter int WIDTH = 361,
  parameter int DEPTH = 410,
  parameter int CW    = $clog2(WIDTH),
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

  // Advancing from the final position holds it, so the frame end stays visible.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv && !last) begin
      if (row_q == ROW_MAX) begin
        row_d = '0;
        col_d = col_q + CW'(1);
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/lowpass_frame_ctrl.sv
// rtl/lowpass_frame_ctrl.sv - frame sequencer for the 3x3 low-pass datapath; LOWPASS_FRAME_CTRL_PERF_EN adds cycle counters
module lowpass_frame_ctrl
  import lowpass_pkg::*;
#(
  parameter int WIDTH = 361,
  parameter int DEPTH = 410,
  parameter int LAT   = 2,
  parameter int CW    = $clog2(WIDTH),
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          load_en,
  output logic [CW-1:0] load_col,
  output logic [RW-1:0] load_row,
  output logic          proc_en,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic [3:0]    border,
  output logic          pipe_adv,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          busy,
  output logic          done
`ifdef LOWPASS_FRAME_CTRL_PERF_EN
  ,
  output logic [31:0]   frame_cycles,
  output logic [31:0]   stall_cycles
`endif
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH - 1);

  state_e         state_q, state_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic           load_last;
  logic           win_last;
  logic           frame_clr;

  assign frame_clr = (state_q == IDLE) && start;
  assign out_valid = vld_q[LAT-1];
  assign pipe_adv  = out_ready | ~out_valid;
  assign load_en   = in_valid & in_ready;
  assign busy      = (state_q != IDLE);

  raster_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW), .RW(RW)) u_load_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (frame_clr),
    .adv  (load_en),
    .col  (load_col),
    .row  (load_row),
    .last (load_last)
  );

  raster_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW), .RW(RW)) u_win_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (frame_clr),
    .adv  (proc_en),
    .col  (win_col),
    .row  (win_row),
    .last (win_last)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    proc_en  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (load_en && load_last) state_d = PROC;
      end
      PROC: begin
        proc_en = pipe_adv;
        if (pipe_adv && win_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the final result is being accepted this cycle.
        if (vld_d == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    if (pipe_adv) begin
      vld_d[0] = proc_en;
      for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    border             = '0;
    border[BRD_TOP]    = (win_row == '0);
    border[BRD_BOTTOM] = (win_row == ROW_MAX);
    border[BRD_LEFT]   = (win_col == '0);
    border[BRD_RIGHT]  = (win_col == COL_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
    end
  end

`ifdef LOWPASS_FRAME_CTRL_PERF_EN
  logic [31:0] frame_cycles_q, frame_cycles_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  assign frame_cycles = frame_cycles_q;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    frame_cycles_d = frame_cycles_q;
    stall_cycles_d = stall_cycles_q;
    if (frame_clr) begin
      frame_cycles_d = '0;
      stall_cycles_d = '0;
    end else begin
      if (busy && (frame_cycles_q != 32'hFFFF_FFFF))
        frame_cycles_d = frame_cycles_q + 32'd1;
      if (out_valid && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      frame_cycles_q <= frame_cycles_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
`endif

endmodule

// File: tb/tb_lowpass_frame_ctrl.sv
// tb/tb_lowpass_frame_ctrl.sv - scoreboard bench for lowpass_frame_ctrl on a 3x4 frame (LOWPASS_FRAME_CTRL_PERF_EN optional)
module tb_lowpass_frame_ctrl;

  localparam int W = 3;
  localparam int D = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, load_en, proc_en, pipe_adv, out_valid, busy, done;
  logic [1:0] load_col, win_col;
  logic [1:0] load_row, win_row;
  logic [3:0] border;
`ifdef LOWPASS_FRAME_CTRL_PERF_EN
  logic [31:0] frame_cycles, stall_cycles;
`endif

  always #5 clk = ~clk;

  lowpass_frame_ctrl #(.WIDTH(W), .DEPTH(D), .LAT(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_en   (load_en),
    .load_col  (load_col),
    .load_row  (load_row),
    .proc_en   (proc_en),
    .win_col   (win_col),
    .win_row   (win_row),
    .border    (border),
    .pipe_adv  (pipe_adv),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
`ifdef LOWPASS_FRAME_CTRL_PERF_EN
    ,
    .frame_cycles (frame_cycles),
    .stall_cycles (stall_cycles)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_load[$];
  logic [7:0] exp_win[$];
  int         exp_out[$];
  logic [3:0] brd_tbl[12];

  logic       m_v[2];
  int         m_idx[2];
  int         proc_cnt;
  logic       mon_adv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation or bound expired", name);
  endtask

  // Cycle model of the valid pipe plus scoreboard pops for every DUT-presented transfer.
  always @(negedge clk) begin
    if (rst) begin
      m_v[0]   = 1'b0;
      m_v[1]   = 1'b0;
      m_idx[0] = 0;
      m_idx[1] = 0;
      proc_cnt = 0;
    end else begin
      if (start && !busy) proc_cnt = 0;
      chk("out_valid", 32'(out_valid), 32'(m_v[1]));
      mon_adv = out_ready | ~m_v[1];
      chk("pipe_adv", 32'(pipe_adv), 32'(mon_adv));
      if (load_en) begin
        if (exp_load.size() == 0) fail_now("load_extra");
        else chk("load_addr", 32'({load_col, load_row}), 32'(exp_load.pop_front()));
      end
      if (proc_en) begin
        if (exp_win.size() == 0) fail_now("proc_extra");
        else chk("win_pos_border", 32'({win_col, win_row, border}), 32'(exp_win.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now("out_extra");
        else chk("out_order", 32'(m_idx[1]), 32'(exp_out.pop_front()));
      end
      if (mon_adv) begin
        m_v[1]   = m_v[0];
        m_idx[1] = m_idx[0];
        m_v[0]   = proc_en;
        m_idx[0] = proc_cnt;
      end
      if (proc_en) proc_cnt++;
    end
  end

  task automatic push_frame();
    for (int c = 0; c < W; c++) begin
      for (int r = 0; r < D; r++) begin
        exp_load.push_back({2'(c), 2'(r)});
        exp_win.push_back({2'(c), 2'(r), brd_tbl[c*D + r]});
        exp_out.push_back(c*D + r);
      end
    end
  endtask

  task automatic run_frame(input bit toggle, input bit stall);
    int cyc = 0, busy_cnt = 0, stall_obs = 0, stall_left = 0;
    int first_proc = -1, first_out = -1, last_hs = -1, done_cyc = -1;
    int n_load = 0, n_proc = 0, n_hs = 0;
    bit stalled = 0, done_seen = 0;
    logic [3:0] frz = '0;
    push_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (in_ready) chk("load_en_gate", 32'(load_en), 32'(in_valid));
      if (load_en) n_load++;
      if (proc_en) begin
        n_proc++;
        if (first_proc < 0) first_proc = cyc;
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        n_hs++;
        last_hs = cyc;
      end
      if (out_valid && !out_ready) begin
        stall_obs++;
        chk("stall_pipe_adv", 32'(pipe_adv), 32'd0);
        chk("stall_proc_en", 32'(proc_en), 32'd0);
        chk("stall_win_frozen", 32'({win_col, win_row}), 32'(frz));
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      cyc++;
      @(posedge clk); #1;
      in_valid = toggle ? ~in_valid : 1'b1;
      if (stall && !stalled && out_valid) begin
        stalled    = 1;
        stall_left = 5;
        frz        = {win_col, win_row};
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    if (!done_seen) fail_now("done_timeout");
    chk("load_count", 32'(n_load), 32'd12);
    chk("proc_count", 32'(n_proc), 32'd12);
    chk("out_count", 32'(n_hs), 32'd12);
    chk("first_out_latency", 32'(first_out - first_proc), 32'd2);
    chk("done_after_last_out", 32'(done_cyc - last_hs), 32'd1);
    chk("stall_cycles_seen", 32'(stall_obs), stall ? 32'd5 : 32'd0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("load_queue_empty", 32'(exp_load.size()), 32'd0);
    chk("win_queue_empty", 32'(exp_win.size()), 32'd0);
    chk("out_queue_empty", 32'(exp_out.size()), 32'd0);
`ifdef LOWPASS_FRAME_CTRL_PERF_EN
    chk("frame_cycles", frame_cycles, 32'(busy_cnt));
    chk("stall_cycles", stall_cycles, stall ? 32'd5 : 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_load_en"}, 32'(load_en), 32'd0);
    chk({tag, "_proc_en"}, 32'(proc_en), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_border"}, 32'(border), 32'hA);
    chk({tag, "_pipe_adv"}, 32'(pipe_adv), 32'd1);
    chk({tag, "_win_pos"}, 32'({win_col, win_row}), 32'd0);
  endtask

  initial begin
    // Hand-computed {top,bottom,left,right} per window, column-major.
    brd_tbl[0]  = 4'b1010; brd_tbl[1]  = 4'b0010; brd_tbl[2]  = 4'b0010; brd_tbl[3]  = 4'b0110;
    brd_tbl[4]  = 4'b1000; brd_tbl[5]  = 4'b0000; brd_tbl[6]  = 4'b0000; brd_tbl[7]  = 4'b0100;
    brd_tbl[8]  = 4'b1001; brd_tbl[9]  = 4'b0001; brd_tbl[10] = 4'b0001; brd_tbl[11] = 4'b0101;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1 rst = 1'b0;

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 1);

    begin : mid_frame_reset
      int  guard = 0;
      bit  hit   = 0;
      push_frame();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (!hit && guard < 100) begin
        @(negedge clk);
        if (proc_en && win_col == 2'd1 && win_row == 2'd2) hit = 1;
        guard++;
      end
      if (!hit) fail_now("reach_window_1_2");
      #1 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      exp_load.delete();
      exp_win.delete();
      exp_out.delete();
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
    end

    run_frame(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lowpass_frame_ctrl.md
Name: lowpass_frame_ctrl

Overview:
- Sequencer for the 3x3 low-pass filter datapath.
- Runs one frame per `start`: loads WIDTH x DEPTH pixels column-major (col outer, row inner) through a valid/ready source, then issues one window per cycle to the filter pipeline, then drains it.
- Supplies write addresses, window-centre coordinates, border flags for zero padding, and a pipeline advance enable. Sits between the pixel source/sink and the filter datapath.

Parameters:
- WIDTH, 361, image columns (>=2)
- DEPTH, 410, image rows (>=2)
- LAT, 2, filter pipeline latency in advancing cycles, proc_en to result (>=1)
- CW, $clog2(WIDTH), column counter width
- RW, $clog2(DEPTH), row counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin frame; sampled only in IDLE
- in_valid  in  1  source pixel valid
- in_ready  out  1  controller accepts pixel
- load_en  out  1  datapath pixel-store write enable
- load_col  out  CW  write column
- load_row  out  RW  write row
- proc_en  out  1  launch window at win_col/win_row this cycle
- win_col  out  CW  window centre column
- win_row  out  RW  window centre row
- border  out  4  {top,bottom,left,right}; datapath substitutes 0 for out-of-image neighbours
- pipe_adv  out  1  clock enable for all filter pipeline stages
- out_ready  in  1  sink accepts result
- out_valid  out  1  result on datapath output valid
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- States (package enum): IDLE, LOAD, PROC, DRAIN, DONE.
- Reset: async. State IDLE; all counters 0; valid pipe cleared.
- Reset values: in_ready=0, load_en=0, proc_en=0, out_valid=0, busy=0, done=0.
- Post-reset derived outputs: border=4'b1010 (combinational from win counters at 0,0); pipe_adv=1.
- Reset mid-frame: abort immediately; no done pulse.
- IDLE:
  - start=1 -> LOAD; load and win counters cleared.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - load_en = in_valid & in_ready (combinational).
  - load_col/load_row are the registered load counters.
  - On accept: row++; at row==DEPTH-1, row wraps to 0 and col++.
  - Accepting (WIDTH-1, DEPTH-1) -> PROC next cycle. Load counters hold their final value.
- PROC:
  - pipe_adv = out_ready | ~out_valid.
  - proc_en = pipe_adv.
  - win counters advance only when proc_en=1, using the same raster order and wrap as the load counters.
  - Issuing window (WIDTH-1, DEPTH-1) -> DRAIN.
- Valid pipe:
  - LAT-deep shift register, shifting only when pipe_adv=1. Input is proc_en; out_valid is the tail.
  - With out_ready held high, the first out_valid occurs exactly LAT cycles after the first proc_en.
- Backpressure: out_valid=1 & out_ready=0 -> pipe_adv=0; whole pipeline and win counters freeze; no window lost or duplicated.
- DRAIN:
  - proc_en=0; pipe_adv keeps the same rule.
  - When the valid pipe is empty (all WIDTH*DEPTH results accepted) -> DONE.
- DONE: done=1 for one cycle -> IDLE; busy=0 from the following cycle.
- border bits: top=(win_row==0), bottom=(win_row==DEPTH-1), left=(win_col==0), right=(win_col==WIDTH-1).
- Counter compares use exact equality; counters never exceed WIDTH-1/DEPTH-1.
- Exactly WIDTH*DEPTH load_en pulses, proc_en pulses and out_valid&out_ready handshakes per frame.

Optional Feature:
- Macro: LOWPASS_FRAME_CTRL_PERF_EN.
- Defined:
  - Adds output ports frame_cycles[31:0] and stall_cycles[31:0].
  - Both clear on start. frame_cycles counts every cycle busy=1. stall_cycles counts cycles with out_valid=1 & out_ready=0.
  - Both saturate at 32'hFFFFFFFF and hold their value after done. Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package lowpass_pkg:
  - state enum.
  - border bit index constants (BRD_TOP=3, BRD_BOTTOM=2, BRD_LEFT=1, BRD_RIGHT=0).
- Sub-module raster_counter:
  - params WIDTH, DEPTH.
  - inputs clk, rst, clr, adv.
  - outputs col, row, last.
  - Instantiated twice: load counters and window counters.

Test Plan:
- WIDTH=3, DEPTH=4, LAT=2, in_valid and out_ready held 1, start pulse:
  - load_en for 12 consecutive cycles, (col,row) sequence (0,0),(0,1)..(2,3).
  - Then 12 proc_en pulses; first out_valid 2 cycles after first proc_en.
  - done pulses 1 cycle after the 12th output; busy low thereafter.
- Border check: window (0,0) -> border=4'b1010; (1,1) -> 4'b0000; (2,3) -> 4'b0101.
- in_valid toggled 1,0,1,0 during LOAD: load_en only on valid cycles; load counters hold on gaps; still exactly 12 writes.
- out_ready forced 0 for 5 cycles while out_valid=1: pipe_adv=0, win counters frozen, no proc_en. Resume: all 12 results delivered in order, none duplicated.
- rst asserted mid-PROC at window (1,2): outputs go to reset values without a clock edge. Next start runs a complete clean frame from (0,0).
- PERF_EN: run the 5-cycle stall case -> stall_cycles=5, and frame_cycles equals the measured number of busy cycles.
